// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - ordered release of downstream reset domains with per-stage ack and timeout
module reset_release_sequencer #(
    parameter  int N_STAGES    = 4,
    parameter  int HOLD_CYCLES = 16,
    parameter  int ACK_TIMEOUT = 1024,
    localparam int IDX_W       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                CLK,
    input  logic                INTERNAL_RST,
    input  logic                FABRIC_RESET_N,
    input  logic                SW_RST_REQ,
    input  logic [N_STAGES-1:0] STAGE_ACK,
    output logic [N_STAGES-1:0] STAGE_RST_N,
    output logic                SEQ_DONE,
    output logic                SEQ_ERR,
    output logic [IDX_W-1:0]    ERR_STAGE
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TO_W   = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [N_STAGES-1:0] rst_n_q, rst_n_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    err_stage_q, err_stage_d;
    logic [N_STAGES-1:0] ack_meta_q;
    logic [N_STAGES-1:0] ack_s_q;
    logic                abort;

    assign abort = !FABRIC_RESET_N || SW_RST_REQ;

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
        if (!INTERNAL_RST) begin
            state_q     <= S_HOLD;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            ack_meta_q  <= '0;
            ack_s_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rst_n_q     <= rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            ack_meta_q  <= STAGE_ACK;
            ack_s_q     <= ack_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_cnt_d  = hold_cnt_q;
        to_cnt_d    = to_cnt_q;
        rst_n_d     = rst_n_q;
        done_d      = done_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;

        // Abort wins over every state; ERR_STAGE stays as a sticky diagnostic.
        if (abort) begin
            state_d    = S_HOLD;
            idx_d      = '0;
            hold_cnt_d = '0;
            to_cnt_d   = '0;
            rst_n_d    = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    rst_n_d = '0;
                    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        hold_cnt_d = '0;
                        state_d    = S_RELEASE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    rst_n_d[idx_q] = 1'b1;
                    to_cnt_d       = '0;
                    state_d        = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Ack is checked before timeout so a same-cycle ack still succeeds.
                    if (ack_s_q[idx_q]) begin
                        if (idx_q == IDX_W'(N_STAGES - 1)) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_RELEASE;
                        end
                    end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                        err_d       = 1'b1;
                        err_stage_d = idx_q;
                        rst_n_d     = '0;
                        state_d     = S_ERROR;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                end
                S_ERROR: begin
                    err_d   = 1'b1;
                    rst_n_d = '0;
                end
                default: begin
                    state_d = S_HOLD;
                    rst_n_d = '0;
                end
            endcase
        end
    end

    assign STAGE_RST_N = rst_n_q;
    assign SEQ_DONE    = done_q;
    assign SEQ_ERR     = err_q;
    assign ERR_STAGE   = err_stage_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb/tb_reset_release_sequencer.sv - scoreboard bench for reset_release_sequencer
module tb_reset_release_sequencer;

    localparam int N     = 4;
    localparam int H     = 16;
    localparam int T     = 8;
    localparam int NEVER = 1000000;

    logic         CLK;
    logic         INTERNAL_RST;
    logic         FABRIC_RESET_N;
    logic         SW_RST_REQ;
    logic [N-1:0] STAGE_ACK;
    logic [N-1:0] STAGE_RST_N;
    logic         SEQ_DONE;
    logic         SEQ_ERR;
    logic [1:0]   ERR_STAGE;

    reset_release_sequencer #(
        .N_STAGES   (N),
        .HOLD_CYCLES(H),
        .ACK_TIMEOUT(T)
    ) dut (
        .CLK           (CLK),
        .INTERNAL_RST  (INTERNAL_RST),
        .FABRIC_RESET_N(FABRIC_RESET_N),
        .SW_RST_REQ    (SW_RST_REQ),
        .STAGE_ACK     (STAGE_ACK),
        .STAGE_RST_N   (STAGE_RST_N),
        .SEQ_DONE      (SEQ_DONE),
        .SEQ_ERR       (SEQ_ERR),
        .ERR_STAGE     (ERR_STAGE)
    );

    // Expected output change: value {rst_n[3:0], done, err, err_stage[1:0]} appearing at edge 'at'
    typedef struct {
        int         at;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc        = 0;
    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] m_last     = '0;
    logic [7:0] last_obs   = '0;
    logic [7:0] obs;
    ev_t        mon_e;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc = cyc + 1;

    always @(negedge CLK) begin
        obs = {STAGE_RST_N, SEQ_DONE, SEQ_ERR, ERR_STAGE};
        if (obs !== last_obs) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change edge=%0d got=%h, no change expected from %h", cyc, obs, last_obs);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.val !== obs || mon_e.at != cyc) begin
                    miscompares++;
                    $display("FAIL output_event got=%h at edge %0d, expected %h at edge %0d",
                             obs, cyc, mon_e.val, mon_e.at);
                end
            end
            last_obs = obs;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // kind: 0 = end with FABRIC_RESET_N low pulse, 1 = SW_RST_REQ pulse, 2 = async INTERNAL_RST
    // ref_sel: -1 = first hold edge, 0..N-1 = release edge of that stage, N = last scheduled event
    task automatic run_seq(input int d0, input int d1, input int d2, input int d3,
                           input bit use_drop, input int ref_sel, input int off, input int kind);
        int         d[N];
        int         rel[N];
        int         ackset[N];
        int         dropt[N];
        int         e0, r, s, x, cut, last_edge;
        bit         ended;
        logic [1:0] es;
        logic [7:0] nv;
        ev_t        evs[$];

        d  = '{d0, d1, d2, d3};
        e0 = cyc + 1;
        r  = e0 + H;
        ended     = 1'b0;
        last_edge = r;
        es        = m_last[1:0];
        for (int k = 0; k < N; k++) begin
            rel[k] = NEVER; ackset[k] = NEVER; dropt[k] = NEVER;
        end
        for (int k = 0; k < N; k++) begin
            if (!ended) begin
                rel[k] = r;
                evs.push_back('{r, {4'((1 << (k + 1)) - 1), 1'b0, 1'b0, es}});
                ackset[k] = (d[k] == NEVER) ? NEVER : r + d[k];
                if (d[k] == NEVER) s = NEVER;
                else s = (ackset[k] + 3 > r + 1) ? ackset[k] + 3 : r + 1;
                if (s <= r + T) begin
                    if (use_drop && $urandom_range(0, 1) == 1)
                        dropt[k] = s + 1 + int'($urandom_range(0, 3));
                    if (k == N - 1) begin
                        evs.push_back('{s, {4'hF, 1'b1, 1'b0, es}});
                        last_edge = s;
                        ended = 1'b1;
                    end else begin
                        r = s + 1;
                    end
                end else begin
                    es = 2'(k);
                    evs.push_back('{r + T, {4'h0, 1'b0, 1'b1, es}});
                    last_edge = r + T;
                    ended = 1'b1;
                end
            end
        end

        if (ref_sel < 0) x = e0 + off;
        else if (ref_sel >= N || rel[ref_sel] == NEVER) x = last_edge + off;
        else x = rel[ref_sel] + off;
        cut = (kind == 2) ? x - 1 : x;

        foreach (evs[i]) begin
            if (evs[i].at < cut) begin
                exp_q.push_back(evs[i]);
                m_last = evs[i].val;
            end
        end
        nv = {6'b0, (kind == 2) ? 2'b00 : m_last[1:0]};
        if (nv != m_last) begin
            exp_q.push_back('{cut, nv});
            m_last = nv;
        end

        while (cyc < cut) begin
            for (int k = 0; k < N; k++)
                STAGE_ACK[k] = (ackset[k] <= cyc) && (dropt[k] > cyc);
            FABRIC_RESET_N = !(kind == 0 && cyc + 1 == x);
            SW_RST_REQ     = (kind == 1 && cyc + 1 == x);
            @(posedge CLK);
            #1;
        end

        if (kind == 2) begin
            #1;
            INTERNAL_RST = 1'b0;
            #1;
            chk("async_clear", int'({STAGE_RST_N, SEQ_DONE, SEQ_ERR, ERR_STAGE}), 0);
            STAGE_ACK      = '0;
            FABRIC_RESET_N = 1'b1;
            SW_RST_REQ     = 1'b0;
            @(posedge CLK);
            #1;
            INTERNAL_RST = 1'b1;
        end else begin
            STAGE_ACK      = '0;
            FABRIC_RESET_N = 1'b1;
            SW_RST_REQ     = 1'b0;
        end
        @(negedge CLK);
        #1;
        chk("queue_drain", exp_q.size(), 0);
    endtask

    initial begin
        int dd[N];
        int rs, of, kd;
        INTERNAL_RST   = 1'b1;
        FABRIC_RESET_N = 1'b0;
        SW_RST_REQ     = 1'b0;
        STAGE_ACK      = '0;
        #2;
        INTERNAL_RST = 1'b0;
        #1;
        chk("reset_outputs", int'({STAGE_RST_N, SEQ_DONE, SEQ_ERR, ERR_STAGE}), 0);
        repeat (3) @(posedge CLK);
        #1;
        INTERNAL_RST = 1'b1;

        run_seq(3, 3, 3, 3, 1'b0, N, 3, 0);          // nominal to DONE, fabric pulse
        run_seq(1, 2, NEVER, 1, 1'b0, N, 5, 0);      // stage 2 timeout, held until pulse
        run_seq(0, T - 3, 2, 2, 1'b0, N, 2, 1);      // ack seen on last timeout cycle
        run_seq(0, T - 2, 2, 2, 1'b0, N, 2, 1);      // ack one cycle late: error stage 1, SW exit
        run_seq(3, 3, 7, 3, 1'b0, 2, 2, 0);          // abort in WAIT_ACK idx 2
        run_seq(3, 3, 3, 3, 1'b0, -1, 6, 0);         // glitch during HOLD
        run_seq(2, 4, 1, 0, 1'b0, N, 2, 1);          // SW request in DONE
        run_seq(1, 1, NEVER, 1, 1'b0, N, 1, 0);      // sticky ERR_STAGE = 2
        run_seq(2, 2, 6, 2, 1'b0, 2, 3, 2);          // async reset in WAIT_ACK idx 2
        run_seq(-5, -2, 0, 4, 1'b1, N, 3, 1);        // early acks and dropped acks

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < N; k++) begin
                rs = int'($urandom_range(0, 9));
                if (rs == 0) dd[k] = NEVER;
                else if (rs < 3) dd[k] = -int'($urandom_range(1, 10));
                else dd[k] = int'($urandom_range(0, T - 2));
            end
            rs = int'($urandom_range(0, N + 1)) - 1;
            of = (rs < 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(0, 6));
            if (rs == N && of == 0) of = 1;
            kd = int'($urandom_range(0, 2));
            run_seq(dd[0], dd[1], dd[2], dd[3], 1'b1, rs, of, kd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1);
    end

endmodule
